// File: rtl/lsu_ram_if.sv
// Bundle of the pipeline request/response handshake and the 64-bit RAM data
// port. The master modport is the load/store unit; the slave modport is the
// side holding the pipeline and the RAM.
//
// Handshake rule for both channels: a transfer happens on the rising clock
// edge where valid and ready are both high. The LSU's req_ready is high only
// while idle, and resp_valid stays high with stable data until resp_ready.
interface lsu_ram_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    logic [63:0] ram_addr;
    logic        ram_r_ena;
    logic        ram_w_ena;
    logic [63:0] ram_w_mask;
    logic [63:0] ram_w_data;
    logic [63:0] ram_r_data;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, ram_r_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_addr, ram_r_ena, ram_w_ena, ram_w_mask, ram_w_data
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, ram_r_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_addr, ram_r_ena, ram_w_ena, ram_w_mask, ram_w_data
    );
endinterface

// File: rtl/lsu_ram_master.sv
// Load/store unit front end for the 64-bit RAM data port: byte-lane alignment,
// write-mask generation, load extension and address-range checking.
// Optional macro LSU_MISALIGN_SPLIT_EN: accesses crossing an 8-byte boundary
// run as two RAM accesses (ACC0, ACC1). Without it any misaligned access
// returns an error and never touches the RAM.
// dbg_state exposes the FSM state (0 IDLE, 1 ACC0, 2 ACC1, 3 RESP).
module lsu_ram_master #(
    parameter logic [63:0] ADDR_LO = 64'h0000_0000_8000_0000,
    parameter logic [63:0] ADDR_HI = 64'h0000_0000_8800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_ram_if.master   bus,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] lo_q, lo_d;
    logic [63:0] hi_q, hi_d;
    logic        err_q, err_d;

    // Request-side checks, evaluated on the incoming request while idle.
    logic [2:0]  req_off;
    logic [3:0]  req_nbytes;
    logic [64:0] req_end;
    logic        req_oor;
    logic        req_misaligned;

    // Latched-request derived values.
    logic [2:0]  off;
    logic [3:0]  nbytes;
    logic [5:0]  sh;
    logic [15:0] lanes16;
    logic [63:0] base_addr;
    logic [7:0]  acc_lanes;
    logic [63:0] load_raw;
    logic [63:0] load_ext;

    assign dbg_state = state_q;

    // Range check is done in 65 bits so addresses near the top cannot wrap.
    always_comb begin
        req_off        = bus.req_addr[2:0];
        req_nbytes     = 4'd1 << bus.req_size;
        req_end        = {1'b0, bus.req_addr} + {61'd0, req_nbytes};
        req_oor        = (bus.req_addr < ADDR_LO) || (req_end > {1'b0, ADDR_HI});
        req_misaligned = (req_off & (req_nbytes[2:0] - 3'd1)) != 3'd0;
    end

    // Lane bookkeeping: lanes16[7:0] are touched by the first access,
    // lanes16[15:8] by the second; load data is the shifted {hi,lo} pair.
    always_comb begin
        off       = addr_q[2:0];
        nbytes    = 4'd1 << size_q;
        sh        = {off, 3'b000};
        lanes16   = ((16'd1 << nbytes) - 16'd1) << off;
        base_addr = {addr_q[63:3], 3'b000};
        load_raw  = (lo_q >> sh) | (hi_q << (7'd64 - {1'b0, sh}));
        load_ext  = load_raw;
        case (size_q)
            2'd0:    load_ext = uns_q ? {56'd0, load_raw[7:0]}  : {{56{load_raw[7]}},  load_raw[7:0]};
            2'd1:    load_ext = uns_q ? {48'd0, load_raw[15:0]} : {{48{load_raw[15]}}, load_raw[15:0]};
            2'd2:    load_ext = uns_q ? {32'd0, load_raw[31:0]} : {{32{load_raw[31]}}, load_raw[31:0]};
            default: load_ext = load_raw;
        endcase
    end

    // Handshake and response outputs follow the state directly.
    assign bus.req_ready  = (state_q == IDLE) && rst_n;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.resp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_ext : 64'd0;

    // Next-state logic and RAM port drive; RAM outputs stay 0 outside ACC0/ACC1.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        err_d   = err_q;

        bus.ram_addr   = 64'd0;
        bus.ram_r_ena  = 1'b0;
        bus.ram_w_ena  = 1'b0;
        bus.ram_w_data = 64'd0;
        bus.ram_w_mask = 64'd0;
        acc_lanes      = 8'd0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    lo_d    = 64'd0;
                    hi_d    = 64'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    err_d   = req_oor;
`else
                    err_d   = req_oor || req_misaligned;
`endif
                    state_d = err_d ? RESP : ACC0;
                end
            end
            ACC0: begin
                bus.ram_addr   = base_addr;
                bus.ram_r_ena  = !we_q;
                bus.ram_w_ena  = we_q;
                bus.ram_w_data = wdata_q << sh;
                acc_lanes      = lanes16[7:0];
                if (!we_q) lo_d = bus.ram_r_data;
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d = (({1'b0, off} + nbytes) > 4'd8) ? ACC1 : RESP;
`else
                state_d = RESP;
`endif
            end
            ACC1: begin
                bus.ram_addr   = base_addr + 64'd8;
                bus.ram_r_ena  = !we_q;
                bus.ram_w_ena  = we_q;
                bus.ram_w_data = wdata_q >> (7'd64 - {1'b0, sh});
                acc_lanes      = lanes16[15:8];
                if (!we_q) hi_d = bus.ram_r_data;
                state_d = RESP;
            end
            default: begin
                if (bus.resp_ready) state_d = IDLE;
            end
        endcase

        for (int i = 0; i < 8; i++) begin
            bus.ram_w_mask[8*i +: 8] = {8{acc_lanes[i]}};
        end
    end

    // State and request registers; async reset returns everything to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            lo_q    <= 64'd0;
            hi_q    <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_ram_master.sv
// Bench for lsu_ram_master: directed vector table, hand-written multi-cycle
// sequences (response back-pressure, reset mid-store) and random traffic
// checked against a byte-array memory model.
module tb_lsu_ram_master;

    localparam logic [63:0] LO = 64'h0000_0000_8000_0000;
    localparam logic [63:0] HI = 64'h0000_0000_8800_0000;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_ram_if bus ();
    logic [1:0] dbg_state;

    lsu_ram_master #(.ADDR_LO(LO), .ADDR_HI(HI)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- RAM: 512-byte window at LO ----------------
    logic [63:0] ram [0:63];
    logic        ram_win;
    logic [5:0]  ram_idx;
    assign ram_win = (bus.ram_addr >= LO) && (bus.ram_addr < LO + 64'd512);
    assign ram_idx = bus.ram_addr[8:3];
    assign bus.ram_r_data = ram_win ? ram[ram_idx] : 64'd0;

    always @(posedge clk) begin
        if (bus.ram_w_ena && ram_win)
            ram[ram_idx] <= (ram[ram_idx] & ~bus.ram_w_mask) | (bus.ram_w_data & bus.ram_w_mask);
    end

    // ---------------- reference model: byte memory ----------------
    logic [7:0] mref [0:511];
    int tests = 0;
    int fails = 0;

    function automatic logic [7:0] m_byte(input logic [63:0] a);
        if (a >= LO && a < LO + 64'd512) return mref[int'(a - LO)];
        return 8'd0;
    endfunction

    function automatic bit m_err(input logic [1:0] size, input logic [63:0] a);
        logic [64:0] e;
        int n;
        n = 1 << size;
        e = {1'b0, a} + 65'(n);
        if (a < LO || e > {1'b0, HI}) return 1'b1;
        if ((a % 64'(n)) != 0 && !SPLIT) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_lat(input logic [1:0] size, input logic [63:0] a);
        int n;
        n = 1 << size;
        if (m_err(size, a)) return 1;
        if (int'(a[2:0]) + n > 8) return 3;
        return 2;
    endfunction

    function automatic logic [63:0] m_load(input logic [1:0] size, input bit uns, input logic [63:0] a);
        logic [63:0] v;
        logic [63:0] keep;
        int n;
        n = 1 << size;
        v = 64'd0;
        for (int i = 0; i < n; i++) v = v | (64'(m_byte(a + 64'(i))) << (8 * i));
        if (size != 2'd3 && !uns && v[8*n-1]) begin
            keep = (64'd1 << (8 * n)) - 64'd1;
            v = v | ~keep;
        end
        return v;
    endfunction

    task automatic m_store(input logic [1:0] size, input logic [63:0] a, input logic [63:0] d);
        logic [63:0] b;
        for (int i = 0; i < (1 << size); i++) begin
            b = a + 64'(i);
            if (b >= LO && b < LO + 64'd512) mref[int'(b - LO)] = d[8*i +: 8];
        end
    endtask

    // ---------------- scoreboard helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    int          acc_n;
    logic [63:0] acc_addr [2];
    logic [63:0] acc_mask [2];
    logic [63:0] acc_wdata [2];
    bit          both_hi;

    task automatic run_txn(input bit we, input logic [1:0] size, input bit uns,
                           input logic [63:0] a, input logic [63:0] d, input int hold,
                           output logic [63:0] rdata, output bit err, output int lat);
        int guard;
        bit done;
        acc_n = 0;
        both_hi = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = a;
        bus.req_wdata = d;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        lat = 0;
        done = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            if (lat == 0) bus.req_valid = 1'b0;
            lat++;
            if (bus.ram_r_ena && bus.ram_w_ena) both_hi = 1;
            if (bus.ram_r_ena || bus.ram_w_ena) begin
                if (acc_n < 2) begin
                    acc_addr[acc_n]  = bus.ram_addr;
                    acc_mask[acc_n]  = bus.ram_w_mask;
                    acc_wdata[acc_n] = bus.ram_w_data;
                end
                acc_n++;
            end
            if (bus.resp_valid) done = 1;
        end
        check("resp_seen", 64'(done), 64'd1);
        check("ena_exclusive", 64'(both_hi), 64'd0);
        check("resp_req_ready_low", 64'(bus.req_ready), 64'd0);
        rdata = bus.resp_rdata;
        err = bus.resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.resp_valid), 64'd1);
            check("hold_rdata", bus.resp_rdata, rdata);
            check("hold_err", 64'(bus.resp_err), 64'(err));
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
            check("hold_ram_idle", 64'({bus.ram_r_ena, bus.ram_w_ena}), 64'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("after_hs_ready", 64'(bus.req_ready), 64'd1);
        check("after_hs_valid", 64'(bus.resp_valid), 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        bit          exp_err;
        int          exp_lat;
        int          exp_nacc;
        logic [63:0] exp_addr0;
        logic [63:0] exp_addr1;
        logic [63:0] exp_mask0;
        logic [63:0] exp_wdata0;
    } vec_t;

    function automatic vec_t mk(input bit we, input logic [1:0] size, input bit uns,
                                input logic [63:0] a, input logic [63:0] d,
                                input logic [63:0] er, input bit ee, input int el, input int en,
                                input logic [63:0] a0, input logic [63:0] a1,
                                input logic [63:0] m0, input logic [63:0] w0);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_nacc = en;
        v.exp_addr0 = a0; v.exp_addr1 = a1; v.exp_mask0 = m0; v.exp_wdata0 = w0;
        return v;
    endfunction

    vec_t vecs [13];

    initial begin
        logic [63:0] rd;
        bit          er;
        int          lt;
        logic [1:0]  sz;
        bit          we, un;
        logic [63:0] a, d;
        int          n;

        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 0;
        for (int i = 0; i < 64; i++) ram[i] = 64'd0;
        for (int i = 0; i < 512; i++) mref[i] = 8'd0;
        // bytes 06..09 = 11,22,33,44 in both RAM and model
        ram[0] = 64'h2211_0000_0000_0000;
        ram[1] = 64'h0000_0000_0000_4433;
        mref[6] = 8'h11; mref[7] = 8'h22; mref[8] = 8'h33; mref[9] = 8'h44;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_ram_en", 64'({bus.ram_r_ena, bus.ram_w_ena}), 64'd0);
        check("rst_ram_addr", bus.ram_addr, 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_release_ready", 64'(bus.req_ready), 64'd1);

        vecs[0]  = mk(1, 3, 0, 64'h8000_0010, 64'h1122_3344_5566_7788, 0, 0, 2, 1,
                      64'h8000_0010, 0, {64{1'b1}}, 64'h1122_3344_5566_7788);
        vecs[1]  = mk(0, 3, 0, 64'h8000_0010, 0, 64'h1122_3344_5566_7788, 0, 2, 1,
                      64'h8000_0010, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 64'h8000_0013, 64'h0000_0000_0000_00F0, 0, 0, 2, 1,
                      64'h8000_0010, 0, 64'h0000_0000_FF00_0000, 64'h0000_0000_F000_0000);
        vecs[3]  = mk(0, 0, 0, 64'h8000_0013, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 2, 1,
                      64'h8000_0010, 0, 0, 0);
        vecs[4]  = mk(0, 0, 1, 64'h8000_0013, 0, 64'h0000_0000_0000_00F0, 0, 2, 1,
                      64'h8000_0010, 0, 0, 0);
        if (SPLIT)
            vecs[5] = mk(0, 2, 0, 64'h8000_0006, 0, 64'h0000_0000_4433_2211, 0, 3, 2,
                         64'h8000_0000, 64'h8000_0008, 0, 0);
        else
            vecs[5] = mk(0, 2, 0, 64'h8000_0006, 0, 64'd0, 1, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 2, 0, 64'h7FFF_FFF8, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 3, 0, 64'h87FF_FFFC, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[8]  = mk(0, 3, 0, 64'h87FF_FFF8, 0, 0, 0, 2, 1, 64'h87FF_FFF8, 0, 0, 0);
        vecs[9]  = mk(0, 3, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 1, 64'h8000_0006, 0, 64'h0000_0000_0000_2211, 0, 2, 1,
                      64'h8000_0000, 0, 0, 0);
        vecs[11] = mk(1, 1, 0, 64'h8000_0020, 64'h0000_0000_0000_ABCD, 0, 0, 2, 1,
                      64'h8000_0020, 0, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_ABCD);
        vecs[12] = mk(0, 1, 0, 64'h8000_0020, 0, 64'hFFFF_FFFF_FFFF_ABCD, 0, 2, 1,
                      64'h8000_0020, 0, 0, 0);

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, 0, rd, er, lt);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_lat", i), 64'(lt), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_nacc", i), 64'(acc_n), 64'(vecs[i].exp_nacc));
            if (vecs[i].exp_nacc > 0 && acc_n > 0)
                check($sformatf("vec%0d_addr0", i), acc_addr[0], vecs[i].exp_addr0);
            if (vecs[i].exp_nacc > 1 && acc_n > 1)
                check($sformatf("vec%0d_addr1", i), acc_addr[1], vecs[i].exp_addr1);
            if (vecs[i].we && !vecs[i].exp_err && acc_n > 0) begin
                check($sformatf("vec%0d_mask0", i), acc_mask[0], vecs[i].exp_mask0);
                check($sformatf("vec%0d_wdata0", i), acc_wdata[0] & acc_mask[0], vecs[i].exp_wdata0);
            end
            if (vecs[i].we && !vecs[i].exp_err) m_store(vecs[i].size, vecs[i].addr, vecs[i].wdata);
        end

        // response back-pressure: 5 cycles with resp_ready low
        run_txn(0, 3, 0, 64'h8000_0010, 0, 5, rd, er, lt);
        check("hold_load_rdata", rd, m_load(3, 0, 64'h8000_0010));
        check("hold_load_lat", 64'(lt), 64'd2);

        // reset pulse during ACC0 of a store
        @(negedge clk);
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 3; bus.req_unsigned = 0;
        bus.req_addr = 64'h8000_0040; bus.req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk);
        #2;
        bus.req_valid = 0;
        check("rst_mid_wena_before", 64'(bus.ram_w_ena), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wena_drop", 64'(bus.ram_w_ena), 64'd0);
        check("rst_mid_state", 64'(dbg_state), 64'd0);
        check("rst_mid_resp_valid", 64'(bus.resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_mid_ready", 64'(bus.req_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_mid_no_resp", 64'(bus.resp_valid), 64'd0);
        end
        run_txn(0, 3, 0, 64'h8000_0040, 0, 0, rd, er, lt);
        check("rst_mid_mem_intact", rd, m_load(3, 0, 64'h8000_0040));

        // random traffic against the byte model
        for (int t = 0; t < 200; t++) begin
            we = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            n  = 1 << sz;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 0) a = LO - 64'($urandom_range(1, 16));
                else a = HI - 64'($urandom_range(0, 7));
            end else begin
                a = LO + 64'($urandom_range(0, 503));
                if ($urandom_range(0, 1) == 0) a = a & ~64'(n - 1);
            end
            d = {$urandom, $urandom};
            run_txn(we, sz, un, a, d, $urandom_range(0, 2), rd, er, lt);
            check($sformatf("rnd%0d_err", t), 64'(er), 64'(m_err(sz, a)));
            check($sformatf("rnd%0d_lat", t), 64'(lt), 64'(m_lat(sz, a)));
            check($sformatf("rnd%0d_nacc", t), 64'(acc_n), 64'(m_lat(sz, a) - 1));
            check($sformatf("rnd%0d_rdata", t), rd,
                  (we || m_err(sz, a)) ? 64'd0 : m_load(sz, un, a));
            if (we && !m_err(sz, a)) m_store(sz, a, d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
